// File: rtl/mc_ctrl_if.sv
// Control bundle between the multicycle main FSM and the MIPS datapath.
interface mc_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       op;
  logic             mem_ready;
  logic             mem_req;
  logic             IorD;
  logic             IRwrite;
  logic             memwrite;
  logic             memtoreg;
  logic [1:0]       regdst;
  logic             regwrite;
  logic             alusrcA;
  logic [1:0]       alusrcB;
  logic [2:0]       aluop;
  logic [1:0]       pcsrc;
  logic             pcwrite;
  logic             branch;
  logic             branchne;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  op, mem_ready,
    output mem_req, IorD, IRwrite, memwrite, memtoreg, regdst, regwrite,
           alusrcA, alusrcB, aluop, pcsrc, pcwrite, branch, branchne,
           illegal_op, instr_count
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, IorD, IRwrite, memwrite, memtoreg, regdst, regwrite,
           alusrcA, alusrcB, aluop, pcsrc, pcwrite, branch, branchne,
           illegal_op, instr_count
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM for the multicycle MIPS datapath: sequences instruction
// phases, handshakes memory wait states, traps illegal opcodes and counts
// retired instructions.
module mc_ctrl_fsm #(
  parameter int unsigned CNT_W           = 32,
  parameter bit          MEM_WAIT        = 1'b1,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input logic       clk,
  input logic       reset,
  mc_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  RTEX   = 4'd6,  RTWB  = 4'd7,
    BEQ    = 4'd8,  BNE    = 4'd9,  IEX    = 4'd10, IWB   = 4'd11,
    JUMP   = 4'd12, JAL    = 4'd13, TRAP   = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  state_t           state;
  state_t           state_nx;
  logic             ready;
  logic             retire;
  logic [CNT_W-1:0] cnt;

  assign ready  = MEM_WAIT ? bus.mem_ready : 1'b1;
  // An instruction retires whenever control re-enters FETCH; TRAP never leaves.
  assign retire = (state_nx == FETCH) && (state != FETCH) && (state != TRAP);
  assign bus.instr_count = cnt;

  // State register and retired-instruction counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (retire) cnt <= cnt + CNT_W'(1);
    end
  end

  // Next-state selection from current state, opcode and memory handshake.
  always_comb begin
    state_nx = state;
    case (state)
      FETCH:  if (ready) state_nx = DECODE;
      DECODE: begin
        case (bus.op)
          OP_RTYPE:                         state_nx = RTEX;
          OP_LW, OP_SW:                     state_nx = MEMADR;
          OP_BEQ:                           state_nx = BEQ;
          OP_BNE:                           state_nx = BNE;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_nx = IEX;
          OP_J:                             state_nx = JUMP;
          OP_JAL:                           state_nx = JAL;
          default: state_nx = TRAP_ON_ILLEGAL ? TRAP : FETCH;
        endcase
      end
      MEMADR: state_nx = (bus.op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (ready) state_nx = MEMWB;
      MEMWR:  if (ready) state_nx = FETCH;
      RTEX:   state_nx = RTWB;
      IEX:    state_nx = IWB;
      MEMWB, RTWB, BEQ, BNE, IWB, JUMP, JAL: state_nx = FETCH;
      TRAP:   state_nx = TRAP;
      default: state_nx = FETCH;
    endcase
  end

  // Datapath controls decoded from state; everything is held low during reset.
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.IorD       = 1'b0;
    bus.IRwrite    = 1'b0;
    bus.memwrite   = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.regdst     = 2'b00;
    bus.regwrite   = 1'b0;
    bus.alusrcA    = 1'b0;
    bus.alusrcB    = 2'b00;
    bus.aluop      = 3'b000;
    bus.pcsrc      = 2'b00;
    bus.pcwrite    = 1'b0;
    bus.branch     = 1'b0;
    bus.branchne   = 1'b0;
    bus.illegal_op = 1'b0;
    if (reset) begin
      case (state)
        FETCH: begin
          bus.mem_req = 1'b1;
          bus.alusrcB = 2'b01;
          bus.IRwrite = ready;
          bus.pcwrite = ready;
        end
        DECODE: bus.alusrcB = 2'b11;
        MEMADR: begin
          bus.alusrcA = 1'b1;
          bus.alusrcB = 2'b10;
        end
        MEMRD: begin
          bus.mem_req = 1'b1;
          bus.IorD    = 1'b1;
        end
        MEMWB: begin
          bus.memtoreg = 1'b1;
          bus.regwrite = 1'b1;
        end
        MEMWR: begin
          bus.mem_req  = 1'b1;
          bus.IorD     = 1'b1;
          bus.memwrite = ready;
        end
        RTEX: begin
          bus.alusrcA = 1'b1;
          bus.aluop   = 3'b010;
        end
        RTWB: begin
          bus.regdst   = 2'b01;
          bus.regwrite = 1'b1;
        end
        BEQ, BNE: begin
          bus.alusrcA  = 1'b1;
          bus.aluop    = 3'b001;
          bus.pcsrc    = 2'b01;
          bus.branch   = (state == BEQ);
          bus.branchne = (state == BNE);
        end
        IEX: begin
          bus.alusrcA = 1'b1;
          bus.alusrcB = 2'b10;
          case (bus.op)
            OP_ANDI: bus.aluop = 3'b011;
            OP_ORI:  bus.aluop = 3'b100;
            OP_SLTI: bus.aluop = 3'b101;
            default: bus.aluop = 3'b000;
          endcase
        end
        IWB: bus.regwrite = 1'b1;
        JUMP: begin
          bus.pcsrc   = 2'b10;
          bus.pcwrite = 1'b1;
        end
        JAL: begin
          bus.pcsrc    = 2'b10;
          bus.pcwrite  = 1'b1;
          bus.regdst   = 2'b10;
          bus.regwrite = 1'b1;
        end
        TRAP: bus.illegal_op = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: three configurations (default,
// NOP-on-illegal, 4-bit counter) run the same instruction stream and are
// compared against a per-instruction phase model.
module tb_mc_ctrl_fsm;

  typedef enum int {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_RTEX, P_RTWB,
    P_BEQ, P_BNE, P_IEX, P_IWB, P_JUMP, P_JAL, P_TRAP
  } phase_t;

  typedef struct packed {
    logic       mem_req, iord, irwrite, memwrite, memtoreg;
    logic [1:0] regdst;
    logic       regwrite, alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite, branch, branchne, illegal;
  } cw_t;

  typedef struct {
    phase_t ph;
    logic   rdy;
  } step_t;
  typedef step_t step_q_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  op_v = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mc = '0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  mc_ctrl_if #(.CNT_W(32)) if_a ();
  mc_ctrl_if #(.CNT_W(32)) if_n ();
  mc_ctrl_if #(.CNT_W(4))  if_w ();

  assign if_a.op = op_v;  assign if_a.mem_ready = mem_ready;
  assign if_n.op = op_v;  assign if_n.mem_ready = mem_ready;
  assign if_w.op = op_v;  assign if_w.mem_ready = mem_ready;

  mc_ctrl_fsm #(.CNT_W(32), .MEM_WAIT(1'b1), .TRAP_ON_ILLEGAL(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.master));
  mc_ctrl_fsm #(.CNT_W(32), .MEM_WAIT(1'b1), .TRAP_ON_ILLEGAL(1'b0)) dut_n (
    .clk(clk), .reset(reset), .bus(if_n.master));
  mc_ctrl_fsm #(.CNT_W(4), .MEM_WAIT(1'b1), .TRAP_ON_ILLEGAL(1'b1)) dut_w (
    .clk(clk), .reset(reset), .bus(if_w.master));

  cw_t cw_a, cw_n, cw_w;
  assign cw_a = {if_a.mem_req, if_a.IorD, if_a.IRwrite, if_a.memwrite, if_a.memtoreg,
                 if_a.regdst, if_a.regwrite, if_a.alusrcA, if_a.alusrcB, if_a.aluop,
                 if_a.pcsrc, if_a.pcwrite, if_a.branch, if_a.branchne, if_a.illegal_op};
  assign cw_n = {if_n.mem_req, if_n.IorD, if_n.IRwrite, if_n.memwrite, if_n.memtoreg,
                 if_n.regdst, if_n.regwrite, if_n.alusrcA, if_n.alusrcB, if_n.aluop,
                 if_n.pcsrc, if_n.pcwrite, if_n.branch, if_n.branchne, if_n.illegal_op};
  assign cw_w = {if_w.mem_req, if_w.IorD, if_w.IRwrite, if_w.memwrite, if_w.memtoreg,
                 if_w.regdst, if_w.regwrite, if_w.alusrcA, if_w.alusrcB, if_w.aluop,
                 if_w.pcsrc, if_w.pcwrite, if_w.branch, if_w.branchne, if_w.illegal_op};

  // Expected control word for an instruction phase, straight from the phase table.
  function automatic cw_t exp_cw(phase_t ph, logic [5:0] opc, logic rdy);
    cw_t c = '0;
    case (ph)
      P_FETCH:  begin c.mem_req = 1; c.alusrcb = 2'b01; c.irwrite = rdy; c.pcwrite = rdy; end
      P_DECODE: c.alusrcb = 2'b11;
      P_MEMADR: begin c.alusrca = 1; c.alusrcb = 2'b10; end
      P_MEMRD:  begin c.mem_req = 1; c.iord = 1; end
      P_MEMWB:  begin c.memtoreg = 1; c.regwrite = 1; end
      P_MEMWR:  begin c.mem_req = 1; c.iord = 1; c.memwrite = rdy; end
      P_RTEX:   begin c.alusrca = 1; c.aluop = 3'b010; end
      P_RTWB:   begin c.regdst = 2'b01; c.regwrite = 1; end
      P_BEQ:    begin c.alusrca = 1; c.aluop = 3'b001; c.pcsrc = 2'b01; c.branch = 1; end
      P_BNE:    begin c.alusrca = 1; c.aluop = 3'b001; c.pcsrc = 2'b01; c.branchne = 1; end
      P_IEX: begin
        c.alusrca = 1; c.alusrcb = 2'b10;
        c.aluop = (opc == 6'h0c) ? 3'b011 : (opc == 6'h0d) ? 3'b100 :
                  (opc == 6'h0a) ? 3'b101 : 3'b000;
      end
      P_IWB:    c.regwrite = 1;
      P_JUMP:   begin c.pcsrc = 2'b10; c.pcwrite = 1; end
      P_JAL:    begin c.pcsrc = 2'b10; c.pcwrite = 1; c.regdst = 2'b10; c.regwrite = 1; end
      P_TRAP:   c.illegal = 1;
      default:  ;
    endcase
    return c;
  endfunction

  // Phase sequence of one instruction with the given wait-state counts.
  // Non-memory phases get a random mem_ready, which must be ignored.
  function automatic step_q_t plan(logic [5:0] opc, int fw, int mw);
    step_q_t q;
    for (int i = 0; i < fw; i++) q.push_back('{P_FETCH, 1'b0});
    q.push_back('{P_FETCH, 1'b1});
    q.push_back('{P_DECODE, 1'($urandom)});
    case (opc)
      6'h00: begin q.push_back('{P_RTEX, 1'($urandom)}); q.push_back('{P_RTWB, 1'($urandom)}); end
      6'h23: begin
        q.push_back('{P_MEMADR, 1'($urandom)});
        for (int i = 0; i < mw; i++) q.push_back('{P_MEMRD, 1'b0});
        q.push_back('{P_MEMRD, 1'b1});
        q.push_back('{P_MEMWB, 1'($urandom)});
      end
      6'h2b: begin
        q.push_back('{P_MEMADR, 1'($urandom)});
        for (int i = 0; i < mw; i++) q.push_back('{P_MEMWR, 1'b0});
        q.push_back('{P_MEMWR, 1'b1});
      end
      6'h04: q.push_back('{P_BEQ, 1'($urandom)});
      6'h05: q.push_back('{P_BNE, 1'($urandom)});
      6'h08, 6'h0c, 6'h0d, 6'h0a: begin
        q.push_back('{P_IEX, 1'($urandom)}); q.push_back('{P_IWB, 1'($urandom)});
      end
      6'h02: q.push_back('{P_JUMP, 1'($urandom)});
      6'h03: q.push_back('{P_JAL, 1'($urandom)});
      default: ;
    endcase
    return q;
  endfunction

  task automatic test_reset();
    cw_t exp;
    reset = 1'b0; op_v = 6'h00; mem_ready = 1'b1;
    #1;
    checks++;
    if ({cw_a, cw_n, cw_w} !== '0) begin errors++; $display("FAIL reset_held ctrl=%h required=0", {cw_a, cw_n, cw_w}); end
    checks++;
    if ({if_a.instr_count, if_n.instr_count, if_w.instr_count} !== '0) begin
      errors++; $display("FAIL reset_count count=%h required=0", if_a.instr_count); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    exp = exp_cw(P_FETCH, op_v, 1'b1);
    checks++;
    if (cw_a !== exp) begin errors++; $display("FAIL reset_fetch ctrl=%h required=%h", cw_a, exp); end
    @(negedge clk);
    mem_ready = 1'($urandom);
    #1;
    exp = exp_cw(P_DECODE, op_v, mem_ready);
    checks++;
    if (cw_a !== exp) begin errors++; $display("FAIL reset_decode ctrl=%h required=%h", cw_a, exp); end
    @(negedge clk);
    #1;
    exp = exp_cw(P_RTEX, op_v, mem_ready);
    checks++;
    if ({cw_a, cw_n, cw_w} !== {exp, exp, exp}) begin
      errors++; $display("FAIL reset_rtex ctrl=%h required=%h", cw_a, exp); end
    reset = 1'b0;
    #1;
    checks++;
    if ({cw_a, cw_n, cw_w} !== '0) begin errors++; $display("FAIL reset_abort ctrl=%h required=0", {cw_a, cw_n, cw_w}); end
    @(negedge clk);
    #1;
    checks++;
    if ({cw_a, cw_n, cw_w} !== '0) begin errors++; $display("FAIL reset_hold2 ctrl=%h required=0", {cw_a, cw_n, cw_w}); end
    reset = 1'b1; mem_ready = 1'b0;
    #1;
    exp = exp_cw(P_FETCH, op_v, 1'b0);
    checks++;
    if ({cw_a, cw_n, cw_w} !== {exp, exp, exp}) begin
      errors++; $display("FAIL reset_release ctrl=%h required=%h", cw_a, exp); end
    checks++;
    if ({if_a.instr_count, if_n.instr_count, if_w.instr_count} !== '0) begin
      errors++; $display("FAIL reset_release_count count=%h required=0", if_a.instr_count); end
    mc = '0;
    @(negedge clk);
  endtask

  // Runs one instruction through all three configurations and checks each cycle.
  task automatic test_instr(string tag, logic [5:0] opc, int fw, int mw);
    step_q_t q;
    cw_t exp;
    op_v = opc;
    q = plan(opc, fw, mw);
    foreach (q[i]) begin
      mem_ready = q[i].rdy;
      #1;
      exp = exp_cw(q[i].ph, opc, q[i].rdy);
      checks++;
      if ({cw_a, cw_n, cw_w} !== {exp, exp, exp})
        begin errors++; $display("FAIL %s_%s ctrl=%h/%h/%h required=%h", tag, q[i].ph.name(), cw_a, cw_n, cw_w, exp); end
      checks++;
      if ({if_a.instr_count, if_n.instr_count, if_w.instr_count} !== {mc, mc, mc[3:0]})
        begin errors++; $display("FAIL %s_count count=%0d/%0d/%0d required=%0d", tag, if_a.instr_count, if_n.instr_count, if_w.instr_count, mc); end
      @(negedge clk);
    end
    mc = mc + 1;
  endtask

  task automatic test_lw_waits();
    test_instr("lw_wait", 6'h23, 2, 2);
    test_instr("sw_wait", 6'h2b, 1, 2);
  endtask

  task automatic test_ori();  test_instr("ori", 6'h0d, 0, 0); endtask

  task automatic test_jal();
    test_instr("jal", 6'h03, 0, 0);
    test_instr("j", 6'h02, 0, 0);
  endtask

  task automatic test_random();
    logic [5:0] legal [11] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08,
                               6'h0c, 6'h0d, 6'h0a, 6'h02, 6'h03};
    for (int n = 0; n < 40; n++)
      test_instr("rand", legal[$urandom_range(0, 10)], $urandom_range(0, 2), $urandom_range(0, 2));
  endtask

  task automatic test_back_to_back();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mc = '0;
    for (int n = 0; n < 17; n++) test_instr("beq_b2b", 6'h04, 0, 0);
    #1;
    checks++;
    if (if_w.instr_count !== 4'd1) begin errors++; $display("FAIL beq_wrap count=%0d required=1", if_w.instr_count); end
    checks++;
    if (if_a.instr_count !== 32'd17) begin errors++; $display("FAIL beq_count32 count=%0d required=17", if_a.instr_count); end
  endtask

  task automatic test_illegal();
    step_q_t q;
    cw_t exp, trap;
    op_v = 6'h3f;
    q = plan(op_v, 0, 0);
    foreach (q[i]) begin
      mem_ready = q[i].rdy;
      #1;
      exp = exp_cw(q[i].ph, op_v, q[i].rdy);
      checks++;
      if ({cw_a, cw_n, cw_w} !== {exp, exp, exp})
        begin errors++; $display("FAIL illegal_%s ctrl=%h/%h/%h required=%h", q[i].ph.name(), cw_a, cw_n, cw_w, exp); end
      @(negedge clk);
    end
    trap = exp_cw(P_TRAP, op_v, 1'b0);
    for (int i = 0; i < 10; i++) begin
      mem_ready = 1'($urandom);
      #1;
      checks++;
      if ({cw_a, cw_w} !== {trap, trap})
        begin errors++; $display("FAIL trap_hold ctrl=%h/%h required=%h", cw_a, cw_w, trap); end
      checks++;
      if ({if_a.instr_count, if_w.instr_count} !== {mc, mc[3:0]})
        begin errors++; $display("FAIL trap_count count=%0d/%0d required=%0d", if_a.instr_count, if_w.instr_count, mc); end
      if (i == 0) begin
        exp = exp_cw(P_FETCH, op_v, mem_ready);
        checks++;
        if (cw_n !== exp) begin errors++; $display("FAIL nop_fetch ctrl=%h required=%h", cw_n, exp); end
        checks++;
        if (if_n.instr_count !== mc + 1) begin errors++; $display("FAIL nop_count count=%0d required=%0d", if_n.instr_count, mc + 1); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_lw_waits();
    test_ori();
    test_jal();
    test_random();
    test_back_to_back();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
